// File: rtl/mips_tb_pkg.sv
// Shared types and helpers for the MIPS run/self-check controller.
package mips_tb_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2,
        TIMEOUT  = 2'd3
    } run_state_t;

    localparam logic [31:0] DEFAULT_END_MARKER = 32'hFFFF_FFFF;

    // Rotate-left-by-one within the low w bits (w <= 64); v must be zero above bit w-1.
    function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((v << 1) | ((v >> (w - 1)) & 64'd1)) & mask;
    endfunction

endpackage

// File: rtl/mips_trace_buf.sv
// Circular buffer of the most recent DEPTH folded values; read index 0 is the oldest entry.
module mips_trace_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic              full;
    logic [AW-1:0]     rd_idx;

    assign full = (fill_q == (AW + 1)'(DEPTH));

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (clr) begin
            wptr_d = '0;
            fill_d = '0;
        end else if (wr_en) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + 1'b1;
            if (!full) fill_d = fill_q + 1'b1;
        end
    end

    // Once full, the oldest entry sits at the write pointer; pointer arithmetic wraps on DEPTH.
    always_comb begin
        rd_idx  = full ? (wptr_q + rd_addr) : rd_addr;
        rd_data = ({1'b0, rd_addr} < fill_q) ? mem_q[rd_idx] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            fill_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/mips_run_controller.sv
// Run/self-check controller for a simulated MIPS core: reset sequencing, cycle count, signature, verdict.
// Optional trace buffer of folded values enabled by defining MIPS_TRACE_BUF_EN.
module mips_run_controller
    import mips_tb_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       CYC_W        = 16,
    parameter int unsigned       RESET_CYCLES = 1,
    parameter int unsigned       MAX_CYCLES   = 250,
    parameter logic [DATA_W-1:0] END_MARKER   = DATA_W'(DEFAULT_END_MARKER),
    parameter int unsigned       TRACE_DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [DATA_W-1:0]              cpu_out,
    input  logic [DATA_W-1:0]              expect_sig,
    output logic                           cpu_reset,
    output logic                           running,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [CYC_W-1:0]               cycle_count,
    output logic [DATA_W-1:0]              signature,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_addr,
    output logic [DATA_W-1:0]              trace_data
);
    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

    run_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              trace_wr;
    logic              trace_clr;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cpu_reset_d = cpu_reset_q;
        running_d   = running_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        cycle_d     = cycle_q;
        sig_d       = sig_q;
        prev_d      = prev_q;
        trace_wr    = 1'b0;
        trace_clr   = 1'b0;

        case (state_q)
            RST_HOLD: begin
                cpu_reset_d = 1'b1;
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d     = RUN;
                    hold_d      = '0;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
                prev_d = cpu_out;
                if (cpu_out != prev_q && cpu_out != END_MARKER) begin
                    sig_d    = DATA_W'(rotl1(64'(sig_q), DATA_W)) ^ cpu_out;
                    trace_wr = 1'b1;
                end
                // Marker takes priority over a coincident timeout; verdict uses the pre-edge signature.
                if (cpu_out == END_MARKER) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = (sig_q == expect_sig);
                end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
                    state_d   = TIMEOUT;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            DONE, TIMEOUT: begin
                if (start) begin
                    state_d     = RST_HOLD;
                    hold_d      = '0;
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    cycle_d     = '0;
                    sig_d       = '0;
                    prev_d      = '0;
                    trace_clr   = 1'b1;
                end
            end
            default: state_d = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_HOLD;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
            sig_q       <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            cycle_q     <= cycle_d;
            sig_q       <= sig_d;
            prev_q      <= prev_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;
    assign signature   = sig_q;

`ifdef MIPS_TRACE_BUF_EN
    mips_trace_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .rst     (reset),
        .clr     (trace_clr),
        .wr_en   (trace_wr),
        .wr_data (cpu_out),
        .rd_addr (trace_addr),
        .rd_data (trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_addr, trace_wr, trace_clr};
    assign trace_data   = '0;
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed, table-driven bench for mips_run_controller (RESET_CYCLES=2, MAX_CYCLES=8, TRACE_DEPTH=4).
module tb_mips_run_controller;
    import mips_tb_pkg::*;

    localparam logic [31:0] E = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] cpu_out;
    logic [31:0] expect_sig;
    logic        cpu_reset, running, done, pass, timeout;
    logic [15:0] cycle_count;
    logic [31:0] signature;
    logic [1:0]  trace_addr;
    logic [31:0] trace_data;

    int unsigned checks = 0;
    int unsigned passed = 0;

    mips_run_controller #(
        .DATA_W       (32),
        .CYC_W        (16),
        .RESET_CYCLES (2),
        .MAX_CYCLES   (8),
        .END_MARKER   (E),
        .TRACE_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cpu_out     (cpu_out),
        .expect_sig  (expect_sig),
        .cpu_reset   (cpu_reset),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .signature   (signature),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        st;
        logic [31:0] co;
        logic [31:0] es;
        logic        cr, ru, dn, ps, to;
        logic [15:0] cc;
        logic [31:0] sg;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic st, input logic [31:0] co, input logic [31:0] es,
                                input logic cr, input logic ru, input logic dn, input logic ps,
                                input logic to, input logic [15:0] cc, input logic [31:0] sg);
        vec_t v;
        v.st = st; v.co = co; v.es = es;
        v.cr = cr; v.ru = ru; v.dn = dn; v.ps = ps; v.to = to; v.cc = cc; v.sg = sg;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, ".running"},   32'(running),   32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".pass"},      32'(pass),      32'd0);
        chk({tag, ".timeout"},   32'(timeout),   32'd0);
        chk({tag, ".cycles"},    32'(cycle_count), 32'd0);
        chk({tag, ".sig"},       signature,      32'd0);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        string t;
        v = vq[idx];
        start      = v.st;
        cpu_out    = v.co;
        expect_sig = v.es;
        step();
        t = $sformatf("row%0d", idx);
        chk({t, ".cpu_reset"}, 32'(cpu_reset),   32'(v.cr));
        chk({t, ".running"},   32'(running),     32'(v.ru));
        chk({t, ".done"},      32'(done),        32'(v.dn));
        chk({t, ".pass"},      32'(pass),        32'(v.ps));
        chk({t, ".timeout"},   32'(timeout),     32'(v.to));
        chk({t, ".cycles"},    32'(cycle_count), 32'(v.cc));
        chk({t, ".sig"},       signature,        v.sg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int seg;
        logic [31:0] model;

        reset = 1'b1; start = 1'b0; cpu_out = '0; expect_sig = '0; trace_addr = '0;

        // Reset hold, then run A: 1,1,2,END with golden 0 -> pass
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
        add(0, 2, 0, 0, 1, 0, 0, 0, 3, 0);
        add(0, E, 0, 0, 0, 1, 1, 0, 4, 0);
        add(0, 7, 0, 0, 0, 1, 1, 0, 4, 0);
        // Restart; run B same stream, golden 1 -> fail; start ignored in RUN
        add(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 1, 0, 0, 0, 2, 1);
        add(0, 2, 1, 0, 1, 0, 0, 0, 3, 0);
        add(0, E, 1, 0, 0, 1, 0, 0, 4, 0);
        // Restart; start ignored in RST_HOLD; timeout run holding 5 (golden 5 still no pass)
        add(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 5, 5, 0, 1, 0, 0, 0, 16'(i), 5);
        add(0, 5, 5, 0, 0, 1, 0, 1, 8, 5);
        add(0, E, 5, 0, 0, 1, 0, 1, 8, 5);
        // Restart; marker arrives on cycle_count==7 -> DONE not TIMEOUT
        seg = vq.size();
        add(1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 3, 3, 0, 1, 0, 0, 0, 16'(i), 3);
        add(0, E, 3, 0, 0, 1, 1, 0, 8, 3);

        #12;
        chk_reset_vals("reset");
        chk("reset.trace", trace_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) apply(i);
        // Start pulse from DONE must reproduce the marker run exactly
        for (int i = seg; i < vq.size(); i++) apply(i);

        // Async reset mid-RUN takes effect before the next clock edge
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        chk("mid.running", 32'(running), 32'd1);
        cpu_out = 32'd9; step();
        chk("mid.sig", signature, 32'd9);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async");
        #3 reset = 1'b0; cpu_out = '0;

        // Six distinct values then marker; signature from bench model
        step(); step();
        chk("tr.running", 32'(running), 32'd1);
        model = '0;
        for (int v = 1; v <= 6; v++) begin
            cpu_out = 32'(v);
            model = {model[30:0], model[31]} ^ 32'(v);
            step();
        end
        expect_sig = model;
        cpu_out = E; step();
        chk("tr.done", 32'(done), 32'd1);
        chk("tr.pass", 32'(pass), 32'd1);
        chk("tr.sig", signature, model);
        for (int a = 0; a < 4; a++) begin
            trace_addr = 2'(a);
            #1;
`ifdef MIPS_TRACE_BUF_EN
            chk($sformatf("trace%0d", a), trace_data, 32'(a + 3));
`else
            chk($sformatf("trace%0d", a), trace_data, 32'd0);
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
